dcache_axi_bridge: RTL and testbench

Responder for the data cache's memory-side request interface; converts its level-held single-word read (line-fill) and write-through requests into AXI4-Lite master transactions. Sits between the data cache and the system AXI interconnect. Produces one-cycle `mem_valid` / `mem_wr_done` acknowledgements and flags bus errors.

---
 rtl/dcache_axi_bridge_if.sv | 93 +++++++++
 rtl/dcache_axi_bridge.sv | 235 +++++++++++++++++++++++
 tb/tb_dcache_axi_bridge.sv | 306 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dcache_axi_bridge_if.sv
// -----------------------------------------------------------------------------
// dcache_axi_bridge_if
// Groups the data-cache request/acknowledge signals, the AXI4-Lite master
// channels and the error report of dcache_axi_bridge into one bundle.
//
// Modports:
//   master : the bridge side. Takes cache requests and AXI slave responses,
//            drives acknowledges, AXI request channels and error flags.
//   slave  : the environment side (cache plus AXI slave), the mirror image.
//
// Signal summary:
//   mem_addr/mem_rd/mem_wr/mem_wdata/mem_wstrb : cache request (level-held)
//   mem_rdata/mem_valid/mem_wr_done            : cache acknowledge
//   m_axi_aw*/m_axi_w*/m_axi_b*                : AXI4-Lite write channels
//   m_axi_ar*/m_axi_r*                         : AXI4-Lite read channels
//   bus_err/err_addr                           : error pulse and last bad address
// -----------------------------------------------------------------------------
interface dcache_axi_bridge_if;
   // Cache request side
   logic [31:0] mem_addr;
   logic        mem_rd;
   logic        mem_wr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_wstrb;
   logic [31:0] mem_rdata;
   logic        mem_valid;
   logic        mem_wr_done;

   // AW channel
   logic [31:0] m_axi_awaddr;
   logic [2:0]  m_axi_awprot;
   logic        m_axi_awvalid;
   logic        m_axi_awready;

   // W channel
   logic [31:0] m_axi_wdata;
   logic [3:0]  m_axi_wstrb;
   logic        m_axi_wvalid;
   logic        m_axi_wready;

   // B channel
   logic [1:0]  m_axi_bresp;
   logic        m_axi_bvalid;
   logic        m_axi_bready;

   // AR channel
   logic [31:0] m_axi_araddr;
   logic [2:0]  m_axi_arprot;
   logic        m_axi_arvalid;
   logic        m_axi_arready;

   // R channel
   logic [31:0] m_axi_rdata;
   logic [1:0]  m_axi_rresp;
   logic        m_axi_rvalid;
   logic        m_axi_rready;

   // Error report
   logic        bus_err;
   logic [31:0] err_addr;

   modport master (
      input  mem_addr, mem_rd, mem_wr, mem_wdata, mem_wstrb,
      output mem_rdata, mem_valid, mem_wr_done,
      output m_axi_awaddr, m_axi_awprot, m_axi_awvalid,
      input  m_axi_awready,
      output m_axi_wdata, m_axi_wstrb, m_axi_wvalid,
      input  m_axi_wready,
      input  m_axi_bresp, m_axi_bvalid,
      output m_axi_bready,
      output m_axi_araddr, m_axi_arprot, m_axi_arvalid,
      input  m_axi_arready,
      input  m_axi_rdata, m_axi_rresp, m_axi_rvalid,
      output m_axi_rready,
      output bus_err, err_addr
   );

   modport slave (
      output mem_addr, mem_rd, mem_wr, mem_wdata, mem_wstrb,
      input  mem_rdata, mem_valid, mem_wr_done,
      input  m_axi_awaddr, m_axi_awprot, m_axi_awvalid,
      output m_axi_awready,
      input  m_axi_wdata, m_axi_wstrb, m_axi_wvalid,
      output m_axi_wready,
      output m_axi_bresp, m_axi_bvalid,
      input  m_axi_bready,
      input  m_axi_araddr, m_axi_arprot, m_axi_arvalid,
      output m_axi_arready,
      output m_axi_rdata, m_axi_rresp, m_axi_rvalid,
      input  m_axi_rready,
      input  bus_err, err_addr
   );
endinterface

// File: rtl/dcache_axi_bridge.sv
// -----------------------------------------------------------------------------
// dcache_axi_bridge
// Converts the data cache's level-held single-word read (line fill) and
// write-through requests into AXI4-Lite master transactions, one at a time.
// Each completed transaction produces a one-cycle acknowledge (mem_valid for
// reads, mem_wr_done for writes); a non-OKAY response additionally pulses
// bus_err with the acknowledge and records the address in err_addr.
//
// Ports:
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : dcache_axi_bridge_if.master (cache request/ack, AXI4-Lite, errors)
//
// Every output is driven straight from a register.
// -----------------------------------------------------------------------------
module dcache_axi_bridge #(
   parameter logic [2:0] AXI_PROT = 3'b000
) (
   input  logic                   clk,
   input  logic                   rst_n,
   dcache_axi_bridge_if.master    bus
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WR,
      S_WR_RESP,
      S_WR_ACK,
      S_RD_ADDR,
      S_RD_DATA,
      S_RD_ACK
   } state_t;

   state_t      r_state,       w_state_nxt;

   logic [31:0] r_awaddr,      w_awaddr_nxt;
   logic        r_awvalid,     w_awvalid_nxt;
   logic [31:0] r_wdata,       w_wdata_nxt;
   logic [3:0]  r_wstrb,       w_wstrb_nxt;
   logic        r_wvalid,      w_wvalid_nxt;
   logic        r_bready,      w_bready_nxt;
   logic [31:0] r_araddr,      w_araddr_nxt;
   logic        r_arvalid,     w_arvalid_nxt;
   logic        r_rready,      w_rready_nxt;
   logic [31:0] r_mem_rdata,   w_mem_rdata_nxt;
   logic        r_mem_valid,   w_mem_valid_nxt;
   logic        r_mem_wr_done, w_mem_wr_done_nxt;
   logic        r_bus_err,     w_bus_err_nxt;
   logic [31:0] r_err_addr,    w_err_addr_nxt;

   // AW and W may complete in either order or together; these remember
   // which one has already handshaken.
   logic        r_aw_done,     w_aw_done_nxt;
   logic        r_w_done,      w_w_done_nxt;

   logic        w_aw_hs;
   logic        w_w_hs;
   logic        w_ar_hs;

   assign w_aw_hs = r_awvalid & bus.m_axi_awready;
   assign w_w_hs  = r_wvalid  & bus.m_axi_wready;
   assign w_ar_hs = r_arvalid & bus.m_axi_arready;

   // -------------------------------------------------------------------------
   // Next-state and next-output logic
   // -------------------------------------------------------------------------
   always_comb begin
      w_state_nxt       = r_state;
      w_awaddr_nxt      = r_awaddr;
      w_awvalid_nxt     = r_awvalid;
      w_wdata_nxt       = r_wdata;
      w_wstrb_nxt       = r_wstrb;
      w_wvalid_nxt      = r_wvalid;
      w_bready_nxt      = r_bready;
      w_araddr_nxt      = r_araddr;
      w_arvalid_nxt     = r_arvalid;
      w_rready_nxt      = r_rready;
      w_mem_rdata_nxt   = r_mem_rdata;
      w_mem_valid_nxt   = 1'b0;
      w_mem_wr_done_nxt = 1'b0;
      w_bus_err_nxt     = 1'b0;
      w_err_addr_nxt    = r_err_addr;
      w_aw_done_nxt     = r_aw_done;
      w_w_done_nxt      = r_w_done;

      unique case (r_state)
         S_IDLE: begin
            // Write wins when both requests are present.
            if (bus.mem_wr) begin
               w_awaddr_nxt  = bus.mem_addr;
               w_wdata_nxt   = bus.mem_wdata;
               w_wstrb_nxt   = bus.mem_wstrb;
               w_awvalid_nxt = 1'b1;
               w_wvalid_nxt  = 1'b1;
               w_aw_done_nxt = 1'b0;
               w_w_done_nxt  = 1'b0;
               w_state_nxt   = S_WR;
            end else if (bus.mem_rd) begin
               w_araddr_nxt  = bus.mem_addr;
               w_arvalid_nxt = 1'b1;
               w_state_nxt   = S_RD_ADDR;
            end
         end

         S_WR: begin
            if (w_aw_hs) begin
               w_awvalid_nxt = 1'b0;
               w_aw_done_nxt = 1'b1;
            end
            if (w_w_hs) begin
               w_wvalid_nxt = 1'b0;
               w_w_done_nxt = 1'b1;
            end
            if ((r_aw_done || w_aw_hs) && (r_w_done || w_w_hs)) begin
               w_aw_done_nxt = 1'b0;
               w_w_done_nxt  = 1'b0;
               w_bready_nxt  = 1'b1;
               w_state_nxt   = S_WR_RESP;
            end
         end

         S_WR_RESP: begin
            if (bus.m_axi_bvalid) begin
               w_bready_nxt      = 1'b0;
               w_mem_wr_done_nxt = 1'b1;
               if (bus.m_axi_bresp != 2'b00) begin
                  w_bus_err_nxt  = 1'b1;
                  w_err_addr_nxt = r_awaddr;
               end
               w_state_nxt = S_WR_ACK;
            end
         end

         // mem_wr is still held here; returning to idle without sampling it
         // prevents a duplicate write.
         S_WR_ACK: begin
            w_state_nxt = S_IDLE;
         end

         S_RD_ADDR: begin
            if (w_ar_hs) begin
               w_arvalid_nxt = 1'b0;
               w_rready_nxt  = 1'b1;
               w_state_nxt   = S_RD_DATA;
            end
         end

         S_RD_DATA: begin
            if (bus.m_axi_rvalid) begin
               // Data is forwarded unchanged even on an error response.
               w_mem_rdata_nxt = bus.m_axi_rdata;
               w_rready_nxt    = 1'b0;
               w_mem_valid_nxt = 1'b1;
               if (bus.m_axi_rresp != 2'b00) begin
                  w_bus_err_nxt  = 1'b1;
                  w_err_addr_nxt = r_araddr;
               end
               w_state_nxt = S_RD_ACK;
            end
         end

         S_RD_ACK: begin
            w_state_nxt = S_IDLE;
         end

         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // -------------------------------------------------------------------------
   // State and output registers
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state       <= S_IDLE;
         r_awaddr      <= 32'h0;
         r_awvalid     <= 1'b0;
         r_wdata       <= 32'h0;
         r_wstrb       <= 4'h0;
         r_wvalid      <= 1'b0;
         r_bready      <= 1'b0;
         r_araddr      <= 32'h0;
         r_arvalid     <= 1'b0;
         r_rready      <= 1'b0;
         r_mem_rdata   <= 32'h0;
         r_mem_valid   <= 1'b0;
         r_mem_wr_done <= 1'b0;
         r_bus_err     <= 1'b0;
         r_err_addr    <= 32'h0;
         r_aw_done     <= 1'b0;
         r_w_done      <= 1'b0;
      end else begin
         r_state       <= w_state_nxt;
         r_awaddr      <= w_awaddr_nxt;
         r_awvalid     <= w_awvalid_nxt;
         r_wdata       <= w_wdata_nxt;
         r_wstrb       <= w_wstrb_nxt;
         r_wvalid      <= w_wvalid_nxt;
         r_bready      <= w_bready_nxt;
         r_araddr      <= w_araddr_nxt;
         r_arvalid     <= w_arvalid_nxt;
         r_rready      <= w_rready_nxt;
         r_mem_rdata   <= w_mem_rdata_nxt;
         r_mem_valid   <= w_mem_valid_nxt;
         r_mem_wr_done <= w_mem_wr_done_nxt;
         r_bus_err     <= w_bus_err_nxt;
         r_err_addr    <= w_err_addr_nxt;
         r_aw_done     <= w_aw_done_nxt;
         r_w_done      <= w_w_done_nxt;
      end
   end

   // -------------------------------------------------------------------------
   // Output drive
   // -------------------------------------------------------------------------
   assign bus.m_axi_awaddr  = r_awaddr;
   assign bus.m_axi_awprot  = AXI_PROT;
   assign bus.m_axi_awvalid = r_awvalid;
   assign bus.m_axi_wdata   = r_wdata;
   assign bus.m_axi_wstrb   = r_wstrb;
   assign bus.m_axi_wvalid  = r_wvalid;
   assign bus.m_axi_bready  = r_bready;
   assign bus.m_axi_araddr  = r_araddr;
   assign bus.m_axi_arprot  = AXI_PROT;
   assign bus.m_axi_arvalid = r_arvalid;
   assign bus.m_axi_rready  = r_rready;
   assign bus.mem_rdata     = r_mem_rdata;
   assign bus.mem_valid     = r_mem_valid;
   assign bus.mem_wr_done   = r_mem_wr_done;
   assign bus.bus_err       = r_bus_err;
   assign bus.err_addr      = r_err_addr;

endmodule

// File: tb/tb_dcache_axi_bridge.sv
// -----------------------------------------------------------------------------
// tb_dcache_axi_bridge
// Directed plus randomized stimulus for dcache_axi_bridge. A cycle-stepped
// AXI4-Lite slave with per-transaction wait states answers the bridge; a
// word-level memory model and a latency formula (3 cycles plus every slave
// wait cycle) supply the expected acknowledge timing, data and error report.
// -----------------------------------------------------------------------------
module tb_dcache_axi_bridge;

   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_errors;
   int   cyc;
   bit   prev_ack;

   logic [31:0] exp_err_addr;
   logic [31:0] slave_mem [logic [31:0]];
   logic [31:0] ref_mem   [logic [31:0]];

   dcache_axi_bridge_if bus ();

   dcache_axi_bridge #(
      .AXI_PROT (3'b000)
   ) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] init_word(input logic [31:0] a);
      return a ^ 32'hA5C3_0000;
   endfunction

   function automatic logic [31:0] slave_rd(input logic [31:0] a);
      return slave_mem.exists(a) ? slave_mem[a] : init_word(a);
   endfunction

   function automatic logic [31:0] ref_rd(input logic [31:0] a);
      return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
   endfunction

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                         input logic [3:0] s);
      logic [31:0] r;
      r = old;
      for (int b = 0; b < 4; b++) if (s[b]) r[b*8 +: 8] = d[b*8 +: 8];
      return r;
   endfunction

   // Advance to 1 time unit after the next rising edge; acknowledges must be
   // mutually exclusive and never on two consecutive cycles.
   task automatic tick();
      bit cur;
      bit bad;
      @(posedge clk);
      #1;
      cyc++;
      cur = bus.mem_valid | bus.mem_wr_done;
      bad = (bus.mem_valid & bus.mem_wr_done) | (cur & prev_ack);
      check("ack_exclusive", {31'b0, bad}, 32'h0);
      prev_ack = cur;
   endtask

   task automatic clear_slave();
      bus.m_axi_awready = 1'b0;
      bus.m_axi_wready  = 1'b0;
      bus.m_axi_bvalid  = 1'b0;
      bus.m_axi_bresp   = 2'b00;
      bus.m_axi_arready = 1'b0;
      bus.m_axi_rvalid  = 1'b0;
      bus.m_axi_rresp   = 2'b00;
      bus.m_axi_rdata   = 32'h0;
   endtask

   // Issue one write from an idle cycle and play the slave until the ack.
   // Returns in the idle cycle following the acknowledge.
   task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           input int aw_dly, input int w_dly, input int b_dly,
                           input logic [1:0] resp, input bit hold, input bit also_rd);
      int  aw_hs, w_hs, aw_wait, w_wait, b_wait, lat;
      bit  b_hs, done, ar_seen;
      aw_hs = 0; w_hs = 0; aw_wait = 0; w_wait = 0; b_wait = 0;
      b_hs = 0; done = 0; ar_seen = 0;
      lat = 3 + ((aw_dly > w_dly) ? aw_dly : w_dly) + b_dly;
      bus.mem_addr  = a;
      bus.mem_wdata = d;
      bus.mem_wstrb = s;
      bus.mem_wr    = 1'b1;
      if (also_rd) bus.mem_rd = 1'b1;
      ref_mem[a] = merge(ref_rd(a), d, s);
      for (int k = 1; k <= 60 && !done; k++) begin
         tick();
         if (bus.m_axi_arvalid) ar_seen = 1;
         if (bus.mem_wr_done) begin
            done = 1;
            clear_slave();
            check("wr_latency", k, lat);
            check("wr_aw_count", aw_hs, 1);
            check("wr_w_count", w_hs, 1);
            check("wr_bus_err", {31'b0, bus.bus_err}, {31'b0, resp != 2'b00});
            if (resp != 2'b00) exp_err_addr = a;
            check("wr_err_addr", bus.err_addr, exp_err_addr);
            if (!hold) bus.mem_wr = 1'b0;
         end else begin
            // B is offered once both AW and W completed on earlier edges.
            if (b_hs) begin
               bus.m_axi_bvalid = 1'b0;
            end else if (aw_hs > 0 && w_hs > 0) begin
               bus.m_axi_bvalid = (b_wait >= b_dly);
               bus.m_axi_bresp  = resp;
               if (bus.m_axi_bvalid && bus.m_axi_bready) b_hs = 1;
               else if (!bus.m_axi_bvalid) b_wait++;
            end
            bus.m_axi_awready = bus.m_axi_awvalid && (aw_wait >= aw_dly);
            if (bus.m_axi_awvalid && !bus.m_axi_awready) aw_wait++;
            if (bus.m_axi_awvalid && bus.m_axi_awready) begin
               aw_hs++;
               check("wr_awaddr", bus.m_axi_awaddr, a);
               check("wr_awprot", {29'b0, bus.m_axi_awprot}, 32'h0);
            end
            bus.m_axi_wready = bus.m_axi_wvalid && (w_wait >= w_dly);
            if (bus.m_axi_wvalid && !bus.m_axi_wready) w_wait++;
            if (bus.m_axi_wvalid && bus.m_axi_wready) begin
               w_hs++;
               check("wr_wdata", bus.m_axi_wdata, d);
               check("wr_wstrb", {28'b0, bus.m_axi_wstrb}, {28'b0, s});
               slave_mem[bus.m_axi_awaddr] = merge(slave_rd(bus.m_axi_awaddr),
                                                    bus.m_axi_wdata, bus.m_axi_wstrb);
            end
         end
      end
      check("wr_done_seen", {31'b0, done}, 32'h1);
      check("wr_no_ar", {31'b0, ar_seen}, 32'h0);
      tick();
      bus.mem_wr = 1'b0;
      check("wr_ack_one_cycle", {31'b0, bus.mem_wr_done}, 32'h0);
      check("wr_no_reissue", {31'b0, bus.m_axi_awvalid}, 32'h0);
   endtask

   // Issue one read from an idle cycle; returns in the idle cycle after the ack.
   task automatic do_read(input logic [31:0] a, input int ar_dly, input int r_dly,
                          input logic [1:0] resp, output int ack_cyc);
      int  ar_hs, ar_wait, r_wait, lat;
      bit  r_hs, done, aw_seen;
      ar_hs = 0; ar_wait = 0; r_wait = 0; r_hs = 0; done = 0; aw_seen = 0;
      ack_cyc = 0;
      lat = 3 + ar_dly + r_dly;
      bus.mem_addr = a;
      bus.mem_rd   = 1'b1;
      for (int k = 1; k <= 60 && !done; k++) begin
         tick();
         if (bus.m_axi_awvalid) aw_seen = 1;
         if (bus.mem_valid) begin
            done = 1;
            ack_cyc = cyc;
            clear_slave();
            bus.mem_rd = 1'b0;
            check("rd_latency", k, lat);
            check("rd_ar_count", ar_hs, 1);
            check("rd_data", bus.mem_rdata, ref_rd(a));
            check("rd_bus_err", {31'b0, bus.bus_err}, {31'b0, resp != 2'b00});
            if (resp != 2'b00) exp_err_addr = a;
            check("rd_err_addr", bus.err_addr, exp_err_addr);
         end else begin
            if (r_hs) begin
               bus.m_axi_rvalid = 1'b0;
            end else if (ar_hs > 0) begin
               bus.m_axi_rvalid = (r_wait >= r_dly);
               bus.m_axi_rdata  = slave_rd(a);
               bus.m_axi_rresp  = resp;
               if (bus.m_axi_rvalid && bus.m_axi_rready) r_hs = 1;
               else if (!bus.m_axi_rvalid) r_wait++;
            end
            bus.m_axi_arready = bus.m_axi_arvalid && (ar_wait >= ar_dly);
            if (bus.m_axi_arvalid && !bus.m_axi_arready) ar_wait++;
            if (bus.m_axi_arvalid && bus.m_axi_arready) begin
               ar_hs++;
               check("rd_araddr", bus.m_axi_araddr, a);
               check("rd_arprot", {29'b0, bus.m_axi_arprot}, 32'h0);
            end
         end
      end
      check("rd_done_seen", {31'b0, done}, 32'h1);
      check("rd_no_aw", {31'b0, aw_seen}, 32'h0);
      tick();
      check("rd_ack_one_cycle", {31'b0, bus.mem_valid}, 32'h0);
   endtask

   task automatic check_all_outputs_zero(input string pfx);
      check({pfx, "_awvalid"}, {31'b0, bus.m_axi_awvalid}, 32'h0);
      check({pfx, "_wvalid"},  {31'b0, bus.m_axi_wvalid},  32'h0);
      check({pfx, "_bready"},  {31'b0, bus.m_axi_bready},  32'h0);
      check({pfx, "_arvalid"}, {31'b0, bus.m_axi_arvalid}, 32'h0);
      check({pfx, "_rready"},  {31'b0, bus.m_axi_rready},  32'h0);
      check({pfx, "_mem_valid"}, {31'b0, bus.mem_valid}, 32'h0);
      check({pfx, "_mem_wr_done"}, {31'b0, bus.mem_wr_done}, 32'h0);
      check({pfx, "_bus_err"}, {31'b0, bus.bus_err}, 32'h0);
      check({pfx, "_err_addr"}, bus.err_addr, 32'h0);
      check({pfx, "_mem_rdata"}, bus.mem_rdata, 32'h0);
      check({pfx, "_awaddr"}, bus.m_axi_awaddr, 32'h0);
      check({pfx, "_araddr"}, bus.m_axi_araddr, 32'h0);
      check({pfx, "_prot"}, {26'b0, bus.m_axi_awprot, bus.m_axi_arprot}, 32'h0);
   endtask

   initial begin
      int          t0, t_ack;
      logic [31:0] ra, rd;
      logic [3:0]  rs;
      logic [1:0]  rr;
      n_checks = 0; n_errors = 0; cyc = 0; prev_ack = 0;
      exp_err_addr = 32'h0;
      rst_n = 1'b0;
      bus.mem_addr = 32'h0; bus.mem_rd = 1'b0; bus.mem_wr = 1'b0;
      bus.mem_wdata = 32'h0; bus.mem_wstrb = 4'h0;
      clear_slave();

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check_all_outputs_zero("reset");
      #3 rst_n = 1'b1;
      tick();

      // Single zero-wait write
      do_write(32'h2000_0014, 32'hDEAD_BEEF, 4'b1100, 0, 0, 0, 2'b00, 0, 0);

      // Skewed write: W four cycles after AW, B two cycles late
      do_write(32'h2000_0020, 32'h1234_5678, 4'b1111, 0, 4, 2, 2'b00, 0, 0);

      // Line fill of four words, zero-wait, back to back
      for (int i = 0; i < 4; i++) begin
         slave_mem[32'h100 + 32'(4 * i)] = 32'h11 * 32'(i + 1);
         ref_mem[32'h100 + 32'(4 * i)]   = 32'h11 * 32'(i + 1);
      end
      t0 = cyc;
      for (int i = 0; i < 4; i++) do_read(32'h100 + 32'(4 * i), 0, 0, 2'b00, t_ack);
      check("fill_span", t_ack - t0, 15);

      // Write request held through its acknowledge
      do_write(32'h2000_0030, 32'hCAFE_F00D, 4'b0011, 1, 0, 1, 2'b00, 1, 0);
      tick();
      check("held_no_second_aw", {31'b0, bus.m_axi_awvalid}, 32'h0);

      // Read error response
      do_read(32'h4000_0000, 1, 2, 2'b10, t_ack);

      // Write error response, then an OKAY read that must keep err_addr
      do_write(32'h5000_0008, 32'h0BAD_0BAD, 4'b0001, 2, 1, 0, 2'b11, 0, 0);
      do_read(32'h2000_0014, 0, 1, 2'b00, t_ack);

      // Read and write requested together: write goes first
      do_write(32'h2000_0040, 32'h5555_AAAA, 4'b1111, 0, 0, 0, 2'b00, 0, 1);
      do_read(32'h2000_0040, 0, 0, 2'b00, t_ack);

      // Randomized traffic
      for (int i = 0; i < 40; i++) begin
         ra = 32'h1000 + 32'(4 * $urandom_range(0, 7));
         rr = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(2, 3)) : 2'b00;
         if ($urandom_range(0, 1) == 1) begin
            rd = $urandom;
            rs = 4'($urandom_range(1, 15));
            do_write(ra, rd, rs, $urandom_range(0, 3), $urandom_range(0, 3),
                     $urandom_range(0, 3), rr, 0, 0);
         end else begin
            do_read(ra, $urandom_range(0, 3), $urandom_range(0, 3), rr, t_ack);
         end
      end

      // Reset while waiting for read data
      bus.mem_addr = 32'h300;
      bus.mem_rd   = 1'b1;
      tick();
      check("rst_arvalid_up", {31'b0, bus.m_axi_arvalid}, 32'h1);
      bus.m_axi_arready = 1'b1;
      tick();
      bus.m_axi_arready = 1'b0;
      check("rst_in_rd_data_rready", {31'b0, bus.m_axi_rready}, 32'h1);
      #3 rst_n = 1'b0;
      #1;
      check_all_outputs_zero("async_rst");
      bus.mem_rd = 1'b0;
      exp_err_addr = 32'h0;
      prev_ack = 0;
      tick();
      tick();
      #2 rst_n = 1'b1;
      tick();
      do_read(32'h104, 2, 1, 2'b00, t_ack);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
